// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: OV7670-style DVP transmitter (RGB565, high byte first).
// Pixels come from an internal pattern generator (bars, gradient, solid)
// or from an external first-word-fall-through FIFO. Every output change
// except the pclk rising edge is made on a fall tick, so href and data are
// stable for the whole pclk-high phase.
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_HALF   = 2,
    parameter int PCLK_GATE   = 1
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    input  logic [15:0] pix_in,
    input  logic        pix_empty,
    output logic        pix_rd,
    output logic        dvp_pclk,
    output logic        dvp_href,
    output logic        dvp_vsync,
    output logic [7:0]  dvp_db,
    output logic        frame_done,
    output logic        underflow,
    output logic [15:0] frame_count
);

    // One line-time in pclk periods: two bytes per pixel plus blanking.
    localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int PW    = (PCLK_HALF > 2) ? $clog2(PCLK_HALF) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
    } state_t;

    state_t        st, nst;
    logic [PW-1:0] pre;
    logic          ph;        // 0: next tick raises pclk, 1: next tick is a fall tick
    logic          tick, rtick, ftick;

    logic [15:0]   per, n_per;        // pclk period within line-time / blanking
    logic [15:0]   line_cnt, n_line;  // line-times spent in VSYNC/VBACK/VFRONT
    logic [15:0]   x, n_x, y, n_y;
    logic          bph, n_bph;        // byte phase: 0 = pixel[15:8], 1 = pixel[7:0]
    logic          latch, last;

    logic [1:0]    mode_q;
    logic [15:0]   solid_q;
    logic [15:0]   pix_q;
    logic [15:0]   pat;
    logic [2:0]    bar;

    assign tick  = (pre == PW'(PCLK_HALF - 1));
    assign rtick = tick & ~ph;
    assign ftick = tick & ph;

    // Prescaler: alternating rise/fall ticks every PCLK_HALF cycles.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            ph  <= 1'b0;
        end else if (tick) begin
            pre <= '0;
            ph  <= ~ph;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // pclk: rises on rise ticks (only during href when gated), falls on fall ticks.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            dvp_pclk <= 1'b0;
        end else if (rtick) begin
            dvp_pclk <= (PCLK_GATE != 0) ? dvp_href : 1'b1;
        end else if (ftick) begin
            dvp_pclk <= 1'b0;
        end
    end

    // Next-state and next-counter logic, evaluated for the coming fall tick.
    always_comb begin
        nst    = st;
        n_per  = per;
        n_line = line_cnt;
        n_x    = x;
        n_y    = y;
        n_bph  = bph;
        latch  = 1'b0;
        last   = 1'b0;
        case (st)
            S_IDLE: begin
                if (enable) begin
                    nst    = S_VSYNC;
                    n_per  = '0;
                    n_line = '0;
                    latch  = 1'b1;
                end
            end
            S_VSYNC: begin
                if (per == 16'(LINE - 1)) begin
                    n_per = '0;
                    if (line_cnt == 16'(VSYNC_LINES - 1)) begin
                        nst    = S_VBACK;
                        n_line = '0;
                    end else begin
                        n_line = line_cnt + 16'd1;
                    end
                end else begin
                    n_per = per + 16'd1;
                end
            end
            S_VBACK: begin
                if (per == 16'(LINE - 1)) begin
                    n_per = '0;
                    if (line_cnt == 16'(V_BACK - 1)) begin
                        nst    = S_ACTIVE;
                        n_line = '0;
                        n_x    = '0;
                        n_y    = '0;
                        n_bph  = 1'b0;
                    end else begin
                        n_line = line_cnt + 16'd1;
                    end
                end else begin
                    n_per = per + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (!bph) begin
                    n_bph = 1'b1;
                end else begin
                    n_bph = 1'b0;
                    if (x == 16'(H_ACTIVE - 1)) begin
                        nst   = S_HBLANK;
                        n_per = '0;
                    end else begin
                        n_x = x + 16'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (per == 16'(H_BLANK - 1)) begin
                    n_per = '0;
                    if (y == 16'(V_ACTIVE - 1)) begin
                        nst    = S_VFRONT;
                        n_line = '0;
                        last   = 1'b1;
                    end else begin
                        nst   = S_ACTIVE;
                        n_y   = y + 16'd1;
                        n_x   = '0;
                        n_bph = 1'b0;
                    end
                end else begin
                    n_per = per + 16'd1;
                end
            end
            S_VFRONT: begin
                if (per == 16'(LINE - 1)) begin
                    n_per = '0;
                    if (line_cnt == 16'(V_FRONT - 1)) begin
                        n_line = '0;
                        if (enable) begin
                            nst   = S_VSYNC;
                            latch = 1'b1;
                        end else begin
                            nst = S_IDLE;
                        end
                    end else begin
                        n_line = line_cnt + 16'd1;
                    end
                end else begin
                    n_per = per + 16'd1;
                end
            end
            default: nst = S_IDLE;
        endcase
    end

    // Internal pattern value for the pixel about to be launched.
    always_comb begin
        bar = 3'(n_x / 16'(BAR_W));
        pat = 16'h0000;
        case (mode_q)
            2'd0: begin
                case (bar)
                    3'd0:    pat = 16'hFFFF;
                    3'd1:    pat = 16'hFFE0;
                    3'd2:    pat = 16'h07FF;
                    3'd3:    pat = 16'h07E0;
                    3'd4:    pat = 16'hF81F;
                    3'd5:    pat = 16'hF800;
                    3'd6:    pat = 16'h001F;
                    default: pat = 16'h0000;
                endcase
            end
            2'd1:    pat = {n_y[4:0], n_x[5:0], n_x[4:0]};
            2'd2:    pat = solid_q;
            default: pat = 16'h0000;
        endcase
    end

    // State, counters and registered DVP outputs, all advanced on fall ticks.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            per         <= '0;
            line_cnt    <= '0;
            x           <= '0;
            y           <= '0;
            bph         <= 1'b0;
            mode_q      <= 2'd0;
            solid_q     <= '0;
            pix_q       <= '0;
            pix_rd      <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_vsync   <= 1'b0;
            dvp_db      <= '0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
            frame_count <= '0;
        end else begin
            pix_rd     <= 1'b0;
            frame_done <= 1'b0;
            if (ftick) begin
                st        <= nst;
                per       <= n_per;
                line_cnt  <= n_line;
                x         <= n_x;
                y         <= n_y;
                bph       <= n_bph;
                dvp_href  <= (nst == S_ACTIVE);
                dvp_vsync <= (nst == S_VSYNC);
                dvp_db    <= 8'h00;
                if (latch) begin
                    mode_q  <= mode;
                    solid_q <= solid_rgb;
                end
                // A fresh start from IDLE forgets old underflows; the set below
                // cannot coincide because VSYNC is never an active state.
                if (st == S_IDLE && nst == S_VSYNC)
                    underflow <= 1'b0;
                if (last) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end
                if (nst == S_ACTIVE) begin
                    if (!n_bph) begin
                        if (mode_q == 2'd3) begin
                            if (pix_empty) begin
                                underflow <= 1'b1;
                                pix_q     <= 16'h0000;
                            end else begin
                                pix_rd <= 1'b1;
                                pix_q  <= pix_in;
                                dvp_db <= pix_in[15:8];
                            end
                        end else begin
                            pix_q  <= pat;
                            dvp_db <= pat[15:8];
                        end
                    end else begin
                        dvp_db <= pix_q[7:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: scoreboard of expected pixels, pixel monitor
// capturing bytes at pclk rises, plus timing checks on vsync/href/frame_done.
module tb_dvp_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        enable_b = 1'b0;
    logic [1:0]  mode = 2'd2;
    logic [15:0] solid_rgb = 16'h1234;
    logic [15:0] pix_in = 16'h0000;
    logic        pix_empty = 1'b1;
    logic        pix_rd, dvp_pclk, dvp_href, dvp_vsync, frame_done, underflow;
    logic [7:0]  dvp_db;
    logic [15:0] frame_count;
    logic        b_rd, b_pclk, b_href, b_vsync, b_done, b_uf;
    logic [7:0]  b_db;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_b[$];
    logic [15:0] fifo[$];
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dvp_pattern_tx #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1),
                     .V_BACK(1), .V_FRONT(1), .PCLK_HALF(2), .PCLK_GATE(1)) dut (
        .clk_100(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .solid_rgb(solid_rgb), .pix_in(pix_in), .pix_empty(pix_empty),
        .pix_rd(pix_rd), .dvp_pclk(dvp_pclk), .dvp_href(dvp_href),
        .dvp_vsync(dvp_vsync), .dvp_db(dvp_db), .frame_done(frame_done),
        .underflow(underflow), .frame_count(frame_count));

    // Wide-line instance so each colour bar spans eight pixels.
    dvp_pattern_tx #(.H_ACTIVE(64), .V_ACTIVE(1), .H_BLANK(4), .VSYNC_LINES(1),
                     .V_BACK(1), .V_FRONT(1), .PCLK_HALF(2), .PCLK_GATE(1)) u_bars (
        .clk_100(clk), .rst_n(rst_n), .enable(enable_b), .mode(2'd0),
        .solid_rgb(16'h0000), .pix_in(16'h0000), .pix_empty(1'b1),
        .pix_rd(b_rd), .dvp_pclk(b_pclk), .dvp_href(b_href),
        .dvp_vsync(b_vsync), .dvp_db(b_db), .frame_done(b_done),
        .underflow(b_uf), .frame_count(b_cnt));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // which: 0 = main frame_done, 1 = main href rising, 2 = bars frame_done
    task automatic wait_ev(input int which, input string nm);
        logic prev = dvp_href;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case (which)
                0:       if (frame_done) return;
                1:       if (dvp_href && !prev) return;
                default: if (b_done) return;
            endcase
            prev = dvp_href;
        end
        checks++;
        errors++;
        $display("FAIL wait_%s: no event within 3000 cycles", nm);
    endtask

    task automatic push_solid(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, dvp_pclk, dvp_href, dvp_vsync, dvp_db, pix_rd, frame_done,
                underflow, frame_count};
    endfunction

    // External FIFO model: pop on the strobe, present the new head next cycle.
    always @(negedge clk) begin
        if (rst_n && pix_rd) begin
            rd_cnt++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        pix_empty = (fifo.size() == 0);
        pix_in    = (fifo.size() == 0) ? 16'h0000 : fifo[0];
    end

    // Main monitor: timing of vsync/href, blank data, and pixel capture.
    always @(negedge clk) begin : mon
        int vs_len, hr_len;
        logic bph, pclk_q;
        logic [7:0] hi;
        logic [15:0] pix;
        if (!rst_n) begin
            vs_len = 0; hr_len = 0; bph = 1'b0; pclk_q = 1'b0;
        end else begin
            if (dvp_vsync) vs_len++;
            else if (vs_len != 0) begin chk("vsync_len", vs_len, 80); vs_len = 0; end
            if (dvp_href) hr_len++;
            else if (hr_len != 0) begin
                chk("href_len", hr_len, 64);
                chk("db_blank", {24'h0, dvp_db}, 0);
                hr_len = 0;
            end
            if (!dvp_href) bph = 1'b0;
            else if (dvp_pclk && !pclk_q) begin
                if (!bph) begin hi = dvp_db; bph = 1'b1; end
                else begin
                    bph = 1'b0;
                    pix = {hi, dvp_db};
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pixel: got %04h with no expected pixel", pix);
                    end else chk("pixel", {16'h0, pix}, {16'h0, exp_q.pop_front()});
                end
            end
            pclk_q = dvp_pclk;
        end
    end

    // Bars-instance monitor: pixel capture only.
    always @(negedge clk) begin : mon_b
        logic bph, pclk_q;
        logic [7:0] hi;
        logic [15:0] pix;
        if (!rst_n) begin
            bph = 1'b0; pclk_q = 1'b0;
        end else begin
            if (!b_href) bph = 1'b0;
            else if (b_pclk && !pclk_q) begin
                if (!bph) begin hi = b_db; bph = 1'b1; end
                else begin
                    bph = 1'b0;
                    pix = {hi, b_db};
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bars64_pixel: got %04h with no expected pixel", pix);
                    end else chk("bars64_pixel", {16'h0, pix}, {16'h0, exp_b.pop_front()});
                end
            end
            pclk_q = b_pclk;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        logic [31:0] acc;

        // Reset and idle
        repeat (5) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        acc = 0;
        repeat (1000) begin @(negedge clk); acc |= all_outs(); end
        chk("idle_outputs", acc, 0);

        // Three solid frames back to back
        push_solid(16'h1234, 96);
        enable = 1'b1;
        wait_ev(0, "done1"); t_prev = cyc;
        wait_ev(0, "done2"); chk("done_interval", cyc - t_prev, 560); t_prev = cyc;
        wait_ev(0, "done3"); chk("done_interval", cyc - t_prev, 560); t_prev = cyc;
        chk("frame_count3", {16'h0, frame_count}, 3);

        // Mode change mid-frame: frame 4 stays solid, frame 5 is bars
        push_solid(16'h1234, 32);
        wait_ev(1, "f4_href");
        mode = 2'd0;
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 8; xx++) exp_q.push_back(bars[xx]);
        wait_ev(0, "done4"); chk("done_interval", cyc - t_prev, 560); t_prev = cyc;

        // Enable dropped mid-frame: frame 5 still completes, then idle
        wait_ev(1, "f5_href");
        enable = 1'b0;
        wait_ev(0, "done5"); chk("done_interval", cyc - t_prev, 560);
        chk("frame_count5", {16'h0, frame_count}, 5);
        acc = 0;
        repeat (400) begin @(negedge clk); acc |= {30'h0, dvp_vsync, dvp_href}; end
        chk("idle_after_drop", acc, 0);
        chk("sb_drain_a", exp_q.size(), 0);

        // Gradient frame in raster order
        mode = 2'd1;
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 8; xx++)
                exp_q.push_back(16'((yy << 11) | (xx << 5) | xx));
        enable = 1'b1;
        wait_ev(1, "grad_href");
        enable = 1'b0;
        wait_ev(0, "grad_done");

        // External FIFO with two words short
        mode = 2'd3;
        rd_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            fifo.push_back(16'(i));
            exp_q.push_back(16'(i));
        end
        push_solid(16'h0000, 2);
        @(negedge clk);
        enable = 1'b1;
        wait_ev(1, "ext_href");
        enable = 1'b0;
        wait_ev(0, "ext_done");
        chk("pix_rd_count", rd_cnt, 30);
        chk("underflow_set", {31'h0, underflow}, 1);
        chk("frame_count7", {16'h0, frame_count}, 7);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("underflow_reset", {31'h0, underflow}, 0);
        chk("frame_count_reset", {16'h0, frame_count}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of the third line
        mode = 2'd2;
        solid_rgb = 16'h5A5A;
        push_solid(16'h5A5A, 17);
        enable = 1'b1;
        wait_ev(1, "rst_l1");
        wait_ev(1, "rst_l2");
        wait_ev(1, "rst_l3");
        chk("href_before_reset", {31'h0, dvp_href}, 1);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_href", {31'h0, dvp_href}, 0);
        chk("async_db", {24'h0, dvp_db}, 0);
        chk("async_all", all_outs(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Next frame after reset is complete, starting with full vsync
        push_solid(16'h5A5A, 32);
        wait_ev(1, "post_rst_href");
        enable = 1'b0;
        wait_ev(0, "post_rst_done");
        chk("frame_count_post_rst", {16'h0, frame_count}, 1);

        // Colour bars, eight pixels per bar
        for (int xx = 0; xx < 64; xx++) exp_b.push_back(bars[xx / 8]);
        enable_b = 1'b1;
        repeat (20) @(negedge clk);
        enable_b = 1'b0;
        wait_ev(2, "bars_done");
        repeat (200) @(negedge clk);
        chk("bars_count", {16'h0, b_cnt}, 1);
        chk("bars_quiet", {29'h0, b_rd, b_uf, b_vsync}, 0);

        repeat (50) @(negedge clk);
        chk("sb_drain_main", exp_q.size(), 0);
        chk("sb_drain_bars", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvp_pattern_tx.md
# dvp_pattern_tx

Camera-side DVP transmitter: emulates the OV7670 parallel pixel output (pclk, href, vsync, 8-bit data) in RGB565, two bytes per pixel, high byte first. It sources pixels from an internal test-pattern generator or an external first-word-fall-through FIFO. It sits in bench top-levels and loopback builds, driving the cmos_* inputs of the camera capture path so that path can be exercised without a sensor.

## Interface
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK, 144: pclk periods with href low after each line.
- VSYNC_LINES, 3: line-times with vsync high.
- V_BACK, 17: blank line-times after vsync, before the first active line.
- V_FRONT, 10: blank line-times after the last active line.
- PCLK_HALF, 2: clk_100 cycles per pclk half-period; must be 2 or more.
- PCLK_GATE, 1: 1 = pclk held low while href is low; 0 = free-running pclk.
- clk_100  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; frames start only while high.
- mode  in  2  0 = colour bars, 1 = gradient, 2 = solid, 3 = external FIFO.
- solid_rgb  in  16  pixel value used in mode 2.
- pix_in  in  16  external pixel (FWFT data).
- pix_empty  in  1  external FIFO empty.
- pix_rd  out  1  one-cycle pop strobe to the external FIFO.
- dvp_pclk, dvp_href, dvp_vsync  out  1 each  DVP timing outputs.
- dvp_db  out  8  DVP data.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- underflow  out  1  sticky; an external pixel was needed while pix_empty was high.
- frame_count  out  16  completed frames; wraps 0xFFFF to 0.

## Operation
- Reset value of every output is 0. All outputs are registered.
- Prescaler: counts 0..PCLK_HALF-1 and raises a rise tick and a fall tick alternately. Every output change other than pclk rising happens on a fall tick. Data and href are therefore stable through the whole pclk-high phase.
- Line timing: one line-time is 2*H_ACTIVE + H_BLANK pclk periods.
- States:
  - IDLE: exits when enable=1 at a fall tick.
  - VSYNC: vsync=1 for VSYNC_LINES line-times.
  - VBACK: V_BACK line-times.
  - ACTIVE: href=1 for 2*H_ACTIVE periods.
  - HBLANK: H_BLANK periods with href low. After HBLANK, go to ACTIVE if lines remain, otherwise to VFRONT.
  - VFRONT: V_FRONT line-times. Then go to VSYNC if enable=1, otherwise to IDLE.
- Dropping enable mid-frame never truncates the frame.
- mode and solid_rgb are latched on entry to VSYNC. Changes take effect only at the next frame.
- Counters: x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1). Byte phase 0 drives pixel[15:8]; phase 1 drives pixel[7:0].
- Colour bars, bar index = x / (H_ACTIVE/8):
  - FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Gradient: pixel = {y[4:0], x[5:0], x[4:0]}.
- External mode:
  - pix_rd pulses on the fall tick that launches phase 0; pix_in is captured in that same cycle.
  - If pix_empty=1 then, pix_rd stays 0, the pixel is 0x0000, and underflow sets.
  - underflow clears only on reset or on an IDLE→VSYNC transition.
- dvp_db is 0 whenever href=0.
- frame_done pulses and frame_count increments on the fall tick that ends the last HBLANK of the last active line.
- Reset mid-frame: all outputs go to 0 immediately. The next frame starts with a full VSYNC.

## Timing
- pclk period is 2*PCLK_HALF clk_100 cycles (default 25 MHz).
- href, vsync and db change in the same clk_100 cycle as the pclk falling edge.
- The first pclk rise after href goes high comes PCLK_HALF cycles later. This gives a capture path with a 2-FF synchronizer href_1=href_2=1 at the edge it detects.
- In ACTIVE, pclk toggles every PCLK_HALF cycles.
- With PCLK_GATE=1, pclk stays low from the fall tick that drops href until the fall tick that raises it.
- vsync, VBACK and VFRONT line-times always use the line-time defined above.
- Latency from enable (sampled at a fall tick) to vsync high: 1 clk_100 cycle.

## Test plan
Bench parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_HALF=2.
- Reset/idle: hold enable=0 for 1000 cycles → all outputs remain 0.
- Frame timing: enable=1, mode 2, solid_rgb=0x1234 → vsync high for exactly 80 cycles; 4 href pulses of 64 cycles each; bytes captured at pclk rises are 12,34 repeated; frame_done every 560 cycles; frame_count=3 after 3 frames.
- Colour bars with H_ACTIVE=64 → captured pixels per 8-pixel block are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- External mode: FIFO holds 30 words (0..29) → pix_rd count = 30; last 2 pixels are 0x0000; underflow=1; a reset clears underflow.
- Mid-frame changes: switch mode 2→0 mid-frame → rest of the frame stays solid, next frame is bars. Drop enable mid-frame → frame completes, then IDLE with vsync=0. Assert rst_n mid-line → all outputs 0 within 0 cycles (asynchronous).
- Loopback: drive the capture block with gradient mode → every captured 16-bit word equals {y[4:0], x[5:0], x[4:0]} in raster order.
